// File: rtl/mem_store_buffer.sv
// mem_store_buffer: MEM-stage sb/sh/sw decode feeding a DEPTH-entry store FIFO drained over req/ack,
// with MEM stall on a full buffer or a load hitting a pending store word.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter bit ALIGN_CHECK = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] IR_M,
  input  logic valid_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic stall_M,
  output logic ades_M,
  output logic mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0] mem_be,
  input  logic mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_W - 2;
  logic [5:0] op;
  logic is_sb, is_sh, is_sw, store, load, mis, full, hit, enq, deq;
  logic [3:0] be;
  logic [31:0] data;
  logic [WW-1:0] ent_addr [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [3:0] ent_be [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic unused;
  assign unused = ^IR_M[25:0];
  assign op = IR_M[31:26];
  assign is_sb = op == 6'b101000;
  assign is_sh = op == 6'b101001;
  assign is_sw = op == 6'b101011;
  assign store = is_sb | is_sh | is_sw;
  assign load = op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
  assign mis = ALIGN_CHECK && ((is_sh && addr_M[0]) || (is_sw && addr_M[1:0] != 2'b00));
  assign be = is_sw ? 4'b1111 : is_sh ? (addr_M[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_M[1:0];
  assign data = is_sw ? wdata_M : is_sh ? {2{wdata_M[15:0]}} : {4{wdata_M[7:0]}};
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // Hit compares word addresses only; byte enables are deliberately ignored.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (ent_vld[i] && ent_addr[i] == addr_M[ADDR_W-1:2]);
  end
  assign stall_M = valid_M & ((store & ~mis & full) | (load & hit));
  assign ades_M = valid_M & mis;
  assign enq = valid_M & store & ~mis & ~stall_M;
  assign mem_req = ~empty;
  assign deq = mem_req & mem_ack;
  assign mem_addr = {ent_addr[rd_ptr], 2'b00};
  assign mem_wdata = ent_data[rd_ptr];
  assign mem_be = ent_be[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i] <= '0;
      end
    end else begin
      if (deq) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_vld[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr] <= addr_M[ADDR_W-1:2];
        ent_data[wr_ptr] <= data;
        ent_be[wr_ptr] <= be;
        wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      end
      count <= count + CW'(enq) - CW'(deq);
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: scoreboard bench driving two configurations (DEPTH=4 aligned-check,
// DEPTH=3 no-check) from shared stimulus against a queue-based reference model.
module tb_mem_store_buffer;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, LW = 6'h23;
  logic clk = 0, reset = 1;
  logic [31:0] IR_M = 0, addr_M = 0, wdata_M = 0;
  logic valid_M = 0, ack0 = 0, ack1 = 0;
  logic stall0, ades0, req0, empty0, stall1, ades1, req1, empty1;
  logic [31:0] maddr0, mdata0, maddr1, mdata1;
  logic [3:0] mbe0, mbe1;
  logic [2:0] cnt0;
  logic [1:0] cnt1;
  int n_chk = 0, n_fail = 0;
  ent_t q0[$], q1[$], exp0[$], exp1[$];
  logic [5:0] ops [10] = '{6'h28, 6'h29, 6'h2B, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h0F};

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .ALIGN_CHECK(1)) u0 (
    .clk(clk), .reset(reset), .IR_M(IR_M), .valid_M(valid_M), .addr_M(addr_M), .wdata_M(wdata_M),
    .stall_M(stall0), .ades_M(ades0), .mem_req(req0), .mem_addr(maddr0), .mem_wdata(mdata0),
    .mem_be(mbe0), .mem_ack(ack0), .count(cnt0), .empty(empty0));
  mem_store_buffer #(.DEPTH(3), .ADDR_W(32), .ALIGN_CHECK(0)) u1 (
    .clk(clk), .reset(reset), .IR_M(IR_M), .valid_M(valid_M), .addr_M(addr_M), .wdata_M(wdata_M),
    .stall_M(stall1), .ades_M(ades1), .mem_req(req1), .mem_addr(maddr1), .mem_wdata(mdata1),
    .mem_be(mbe1), .mem_ack(ack1), .count(cnt1), .empty(empty1));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: what the current MEM inputs should do to a buffer whose contents are q.
  function automatic void model(input ent_t q[$], input int depth, input bit align,
                                output bit stall, output bit ades, output bit enq, output ent_t e);
    logic [5:0] op;
    bit st, ld, mis, hit;
    int lane;
    op = IR_M[31:26];
    lane = int'(addr_M[1:0]);
    st = op inside {SB, SH, SW};
    ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    mis = align && ((op == SH && lane % 2 != 0) || (op == SW && lane != 0));
    hit = 0;
    foreach (q[i]) if (q[i].a[31:2] == addr_M[31:2]) hit = 1;
    stall = valid_M && ((st && !mis && q.size() == depth) || (ld && hit));
    ades = valid_M && mis;
    enq = valid_M && st && !mis && !stall;
    e.a = addr_M & ~32'h3;
    if (op == SB) begin
      e.be = 4'(1 << lane);
      e.d = wdata_M[7:0] * 32'h01010101;
    end else if (op == SH) begin
      e.be = lane >= 2 ? 4'b1100 : 4'b0011;
      e.d = wdata_M[15:0] * 32'h00010001;
    end else begin
      e.be = 4'hF;
      e.d = wdata_M;
    end
  endfunction

  task automatic step(input logic [5:0] op, input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic k0, input logic k1);
    bit s0, a0, e0, s1, a1, e1, d0, d1;
    ent_t n0, n1;
    IR_M = {op, 26'($urandom)};
    valid_M = v;
    addr_M = a;
    wdata_M = d;
    ack0 = k0;
    ack1 = k1;
    #1;
    model(q0, 4, 1, s0, a0, e0, n0);
    model(q1, 3, 0, s1, a1, e1, n1);
    chk("stall0", stall0, s0);
    chk("ades0", ades0, a0);
    chk("count0", cnt0, q0.size());
    chk("empty0", empty0, q0.size() == 0);
    chk("req0", req0, q0.size() != 0);
    if (q0.size() != 0) chk("head0", {maddr0, mdata0, mbe0}, q0[0]);
    chk("stall1", stall1, s1);
    chk("ades1", ades1, a1);
    chk("count1", cnt1, q1.size());
    chk("empty1", empty1, q1.size() == 0);
    chk("req1", req1, q1.size() != 0);
    if (q1.size() != 0) chk("head1", {maddr1, mdata1, mbe1}, q1[0]);
    d0 = q0.size() != 0 && k0;
    d1 = q1.size() != 0 && k1;
    @(posedge clk);
    if (d0) void'(q0.pop_front());
    if (e0) begin q0.push_back(n0); exp0.push_back(n0); end
    if (d1) void'(q1.pop_front());
    if (e1) begin q1.push_back(n1); exp1.push_back(n1); end
    #2;
  endtask

  task automatic idle(input int n, input logic k0, input logic k1);
    for (int i = 0; i < n; i++) step(6'h00, 0, 0, 0, k0, k1);
  endtask

  task automatic do_reset();
    reset = 1;
    valid_M = 0;
    #1;
    chk("rst_req0", req0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_head0", {maddr0, mdata0, mbe0}, 0);
    chk("rst_req1", req1, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_head1", {maddr1, mdata1, mbe1}, 0);
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    @(posedge clk);
    #2 reset = 0;
  endtask

  // Write monitor: every accepted memory write must be the oldest outstanding store.
  always @(negedge clk) if (!reset) begin
    if (req0 && ack0) begin
      if (exp0.size() == 0) chk("wr0_extra", req0, 0);
      else chk("wr0", {maddr0, mdata0, mbe0}, exp0.pop_front());
    end
    if (req1 && ack1) begin
      if (exp1.size() == 0) chk("wr1_extra", req1, 0);
      else chk("wr1", {maddr1, mdata1, mbe1}, exp1.pop_front());
    end
  end

  initial begin
    #1;
    chk("init_req0", req0, 0);
    chk("init_cnt1", cnt1, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 0;
    step(SB, 1, 32'h1003, 32'hAB, 0, 0);
    chk("t1_addr", maddr0, 32'h1000);
    chk("t1_be", mbe0, 4'b1000);
    chk("t1_data", mdata0, 32'hABABABAB);
    chk("t1_cnt", cnt0, 1);
    idle(2, 1, 1);
    step(SH, 1, 32'h2002, 32'h1234, 1, 1);
    step(SW, 1, 32'h2004, 32'hDEADBEEF, 1, 1);
    idle(3, 1, 1);
    chk("t2_empty", empty0, 1);
    for (int i = 0; i < 4; i++) step(SW, 1, 32'h5000 + 32'(4 * i), 32'(i), 0, 0);
    step(SW, 1, 32'h5010, 32'h55, 0, 0);
    chk("t3_full_stall", stall0, 1);
    step(SW, 1, 32'h5010, 32'h55, 1, 0);
    chk("t3_cnt3", cnt0, 3);
    step(SW, 1, 32'h5010, 32'h55, 0, 0);
    chk("t3_cnt4", cnt0, 4);
    idle(8, 1, 1);
    step(SW, 1, 32'h3000, 32'h99, 0, 0);
    step(LW, 1, 32'h3002, 0, 0, 0);
    step(LW, 1, 32'h3004, 0, 0, 0);
    step(LW, 1, 32'h3002, 0, 1, 1);
    step(LW, 1, 32'h3002, 0, 0, 0);
    step(SW, 1, 32'h4001, 32'h77, 0, 0);
    chk("t5_cnt0", cnt0, 0);
    chk("t5_addr1", maddr1, 32'h4000);
    chk("t5_be1", mbe1, 4'hF);
    idle(3, 1, 1);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(ops[$urandom_range(0, 9)], $urandom_range(0, 99) < 85, 32'h6000 + $urandom_range(0, 63),
           $urandom, 1'($urandom), 1'($urandom));
    end
    idle(6, 1, 1);
    step(SW, 1, 32'h7000, 32'h1, 0, 0);
    step(SW, 1, 32'h7004, 32'h2, 0, 0);
    chk("t7_cnt1", cnt1, 2);
    do_reset();
    idle(2, 1, 1);
    chk("left0", exp0.size(), 0);
    chk("left1", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- MEM-stage store unit for the pipelined MIPS core; the parametrised successor to the MEM-stage store-decode control.
- Decodes sb/sh/sw from IR_M and generates byte enables plus lane-replicated write data.
- Queues stores in a DEPTH-entry FIFO and drains them to data memory over a req/ack handshake.
- Stalls MEM when the buffer is full, or when a load in MEM hits a pending store word (RAW hazard).

Parameters:
DEPTH, 4, number of buffered stores (any value >= 1; need not be a power of two)
ADDR_W, 32, byte-address width
ALIGN_CHECK, 1, 1 = misaligned sh/sw raise ades_M and are dropped; 0 = low address bits ignored

Ports:
Interface: one clock; reset is asynchronous and active-high.
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
IR_M  in  32  instruction in MEM
valid_M  in  1  IR_M is a real instruction, not a bubble
addr_M  in  ADDR_W  ALU-computed byte address
wdata_M  in  32  rt value to store
stall_M  out  1  hold MEM and earlier stages this cycle
ades_M  out  1  store address error (misaligned)
mem_req  out  1  head entry valid, write requested
mem_addr  out  ADDR_W  word address of head entry, bits [1:0] = 0
mem_wdata  out  32  head write data
mem_be  out  4  head byte enables, bit i = byte lane i (little-endian)
mem_ack  in  1  memory accepted head write this cycle
count  out  $clog2(DEPTH+1)  occupied entries
empty  out  1  count == 0

Behaviour:
- Decode on IR_M[31:26]:
  - stores: sb 101000, sh 101001, sw 101011
  - loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101
  - other opcodes are neither.
- Byte enables and data:
  - sb: be = 4'b0001 << addr_M[1:0]; data = {4{wdata_M[7:0]}}
  - sh: be = 4'b0011 << {addr_M[1],1'b0}; data = {2{wdata_M[15:0]}}
  - sw: be = 4'b1111; data = wdata_M
- Misalignment: sh with addr_M[0]=1, or sw with addr_M[1:0]!=0.
  - ALIGN_CHECK=1: ades_M=1 combinationally while valid_M; store not enqueued; no stall.
  - ALIGN_CHECK=0: ades_M tied 0; offending low bits ignored as the sh/sw formulas above imply.
- Stall, combinational, with no path from mem_ack:
  - stall_M = valid_M & ((store & ~misaligned & full) | (load & hit))
  - full = (count == DEPTH)
  - hit = any occupied entry whose word address equals addr_M[ADDR_W-1:2], regardless of byte enables.
- Enqueue at the rising edge when valid_M & store & ~misaligned & ~stall_M.
  - Entry captures {addr_M[ADDR_W-1:2],2'b00}, data and be.
  - Write pointer wraps DEPTH-1 -> 0.
- Dequeue:
  - mem_req = ~empty. mem_addr/mem_wdata/mem_be always show the head entry.
  - Head signals are stable while mem_req & ~mem_ack.
  - mem_req & mem_ack at an edge pops the head; read pointer wraps DEPTH-1 -> 0.
  - mem_ack with mem_req=0 is ignored.
- Simultaneous enqueue and pop: both take effect; count unchanged.
  - A full buffer still stalls that cycle even if mem_ack=1 (no full-bypass).
- Ordering: strict FIFO; memory sees stores in program order.
- Latency: a store accepted at edge N gives mem_req=1 from edge N if the buffer was empty (zero bypass); earliest write completion is at edge N+1.
- Reset (async, mid-transaction included):
  - pointers and count go to 0 and all entries are cleared.
  - mem_req, mem_addr, mem_wdata, mem_be go to 0 immediately.
  - Pending stores are discarded.
  - stall_M and ades_M are combinational and reflect the inputs.

Test Plan:
- Reset, then sb with addr_M=0x1003, wdata_M=0x000000AB, mem_ack=0 -> after edge: mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, count=1.
- sh to 0x2002 with rt=0x1234, then sw to 0x2004 with rt=0xDEADBEEF, mem_ack held 1 -> writes in order:
  - first: be=1100, data=0x12341234
  - second: be=1111, data=0xDEADBEEF
  - afterwards empty=1.
- DEPTH=4, mem_ack=0, five consecutive sw -> count=4 and stall_M=1 on the 5th. Pulse mem_ack for 1 cycle -> count 3, 5th enqueued next edge, count=4, stall_M=0.
- Load hazard: pending sw to 0x3000, then lw to 0x3002 -> stall_M=1 until that entry pops. lw to 0x3004 -> no stall.
- Misalignment:
  - ALIGN_CHECK=1, sw to 0x4001 -> ades_M=1, count unchanged, stall_M=0.
  - ALIGN_CHECK=0, same store -> enqueued with be=1111, addr 0x4000.
- Pointer wrap and reset: DEPTH=3, 7 stores interleaved with acks -> every write matches its store, in order. Assert reset mid-stream with count=2 -> mem_req=0 and count=0 asynchronously, before the next clock edge.
